inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 22 ++
 rtl/inst_queue_ram.sv | 37 +++
 rtl/inst_queue.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and payload type for the instruction queue.
// Exports INST_WIDTH, ADDR_WIDTH, IQ_DEPTH_LOG, the packed entry type
// iq_entry_t and a saturating 32-bit increment helper.
package inst_queue_pkg;

  localparam int unsigned INST_WIDTH   = 32;
  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned IQ_DEPTH_LOG = 4;

  // One queued instruction: word, PC and predicted-taken bit.
  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
  } iq_entry_t;

  // Increment that sticks at all ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage for inst_queue: one synchronous write port and one
// asynchronous read port, no reset.
// Ports:
//   clk_in    clock
//   we        write enable
//   waddr     write index
//   wdata     entry to write
//   raddr     read index
//   rdata_c   entry at raddr (combinational)
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = IQ_DEPTH_LOG
) (
  input  logic                 clk_in,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  iq_entry_t            wdata,
  input  logic [DEPTH_LOG-1:0] raddr,
  output iq_entry_t            rdata_c
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG;

  iq_entry_t mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and dispatch: circular buffer of
// 2**DEPTH_LOG entries with flush, global enable and combinational head view.
// Optional build macro: INST_QUEUE_STATS_EN adds stall_cnt_out.
// Ports:
//   clk_in, rst_n                     clock, async active-low reset
//   rdy_in                            global enable (low freezes state)
//   flush_in                          discard all entries
//   push_valid_in/inst/pc/pred_in     fetch side offer
//   full_out                          occupancy equals depth
//   pop_in                            dispatch consumes head
//   valid_out, inst/pc/pred_out       head entry (zero when empty)
//   count_out                         occupancy
//   stall_cnt_out (macro only)        saturating count of pushes refused while full
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = IQ_DEPTH_LOG
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  push_valid_in,
  input  logic [INST_WIDTH-1:0] push_inst_in,
  input  logic [ADDR_WIDTH-1:0] push_pc_in,
  input  logic                  push_pred_in,
  output logic                  full_out,
  input  logic                  pop_in,
  output logic                  valid_out,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pred_out,
  output logic [DEPTH_LOG:0]    count_out
`ifdef INST_QUEUE_STATS_EN
  ,
  output logic [31:0]           stall_cnt_out
`endif
);

  localparam int unsigned PW    = DEPTH_LOG;
  localparam int unsigned CW    = DEPTH_LOG + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          push_acc_c, pop_acc_c, flush_acc_c;
  iq_entry_t     wr_entry;
  iq_entry_t     rd_entry_c;

  assign wr_entry = '{inst: push_inst_in, pc: push_pc_in, pred: push_pred_in};

  inst_queue_ram #(
    .DEPTH_LOG (DEPTH_LOG)
  ) u_ram (
    .clk_in  (clk_in),
    .we      (push_acc_c),
    .waddr   (tail_q),
    .wdata   (wr_entry),
    .raddr   (head_q),
    .rdata_c (rd_entry_c)
  );

  // Next-state: flush overrides push/pop; acceptance uses registered full/valid.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    flush_acc_c = 1'b0;
    push_acc_c  = 1'b0;
    pop_acc_c   = 1'b0;

    if (rdy_in) begin
      flush_acc_c = flush_in;
      push_acc_c  = push_valid_in && !full_q && !flush_in;
      pop_acc_c   = pop_in && valid_q && !flush_in;
    end

    if (flush_acc_c) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_acc_c) tail_d = tail_q + PW'(1);
      if (pop_acc_c)  head_d = head_q + PW'(1);
      case ({push_acc_c, pop_acc_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign count_out = count_q;
  assign valid_out = valid_q;
  assign full_out  = full_q;

  // Head view straight from storage, forced to zero when empty.
  assign inst_out = valid_q ? rd_entry_c.inst : '0;
  assign pc_out   = valid_q ? rd_entry_c.pc   : '0;
  assign pred_out = valid_q & rd_entry_c.pred;

`ifdef INST_QUEUE_STATS_EN
  logic [31:0] stall_q;

  // Counts enabled edges where fetch offered while full; flush does not clear it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (rdy_in && push_valid_in && full_q) begin
      stall_q <= sat_inc32(stall_q);
    end
  end

  assign stall_cnt_out = stall_q;
`endif

endmodule
